// File: rtl/alu_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sequencing controller and its ALU:
//   - state_e   : sequencer states, encoded so the value doubles as the
//                 display prompt code (WAIT_A=0 .. SHOW=4)
//   - OP_*      : supported operation codes carried on data_in[2:0]
//   - is_legal_op : returns 1 for a supported operation code
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    CALC    = 3'd3,
    SHOW    = 3'd4
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  // Codes 011, 110 and 111 have no ALU function behind them.
  function automatic logic is_legal_op(input logic [2:0] code);
    logic legal;
    case (code)
      OP_ADD, OP_MUL, OP_AND, OP_SUB, OP_OR: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// -----------------------------------------------------------------------------
// ALU_generalizado
// Combinational n_bits-wide ALU. Operands are treated as two's complement.
// Ports:
//   a, b     in  n_bits  operands
//   sel      in  3       operation code (see alu_pkg OP_*)
//   result   out n_bits  result truncated to n_bits
//   overflow out 1       signed overflow of add/sub/mul; 0 for and/or and
//                        for unsupported codes (result is 0 for those)
// -----------------------------------------------------------------------------
module ALU_generalizado
  import alu_pkg::*;
#(
  parameter int n_bits = 8
) (
  input  logic [n_bits-1:0] a,
  input  logic [n_bits-1:0] b,
  input  logic [2:0]        sel,
  output logic [n_bits-1:0] result,
  output logic              overflow
);

  logic [n_bits-1:0]          b_neg_s;
  logic [n_bits-1:0]          sum_s;
  logic [n_bits-1:0]          diff_s;
  logic signed [2*n_bits-1:0] a_ext_s;
  logic signed [2*n_bits-1:0] b_ext_s;
  logic signed [2*n_bits-1:0] prod_s;
  logic [n_bits:0]            prod_top_s;
  logic                       add_ovf_s;
  logic                       sub_ovf_s;
  logic                       mul_ovf_s;

  // Subtraction is done as A + (~B + 1) so it shares the adder's wrap rules.
  assign b_neg_s = ~b + {{(n_bits-1){1'b0}}, 1'b1};
  assign sum_s   = a + b;
  assign diff_s  = a + b_neg_s;

  // Full-width signed product; the low 2*n_bits bits are exact.
  assign a_ext_s = {{n_bits{a[n_bits-1]}}, a};
  assign b_ext_s = {{n_bits{b[n_bits-1]}}, b};
  assign prod_s  = a_ext_s * b_ext_s;

  // Signed add overflows when like-signed operands give an opposite-signed sum.
  assign add_ovf_s = (a[n_bits-1] == b[n_bits-1]) && (sum_s[n_bits-1] != a[n_bits-1]);
  // Signed sub overflows when unlike-signed operands flip the sign of A.
  assign sub_ovf_s = (a[n_bits-1] != b[n_bits-1]) && (diff_s[n_bits-1] != a[n_bits-1]);
  // Product fits n_bits signed only if its top n_bits+1 bits are a pure sign run.
  assign prod_top_s = prod_s[2*n_bits-1:n_bits-1];
  assign mul_ovf_s  = ~((&prod_top_s) | (~|prod_top_s));

  // Operation select.
  always_comb begin
    result   = {n_bits{1'b0}};
    overflow = 1'b0;
    case (sel)
      OP_ADD: begin
        result   = sum_s;
        overflow = add_ovf_s;
      end
      OP_SUB: begin
        result   = diff_s;
        overflow = sub_ovf_s;
      end
      OP_MUL: begin
        result   = prod_s[n_bits-1:0];
        overflow = mul_ovf_s;
      end
      OP_AND: begin
        result   = a & b;
        overflow = 1'b0;
      end
      OP_OR: begin
        result   = a | b;
        overflow = 1'b0;
      end
      default: begin
        result   = {n_bits{1'b0}};
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Walks the user through entering operand A, operand B and an op code from a
// shared switch bus, fires the ALU for one cycle and holds the registered
// result for the display path until the user acknowledges.
// Ports:
//   clk          in  1       system clock
//   reset        in  1       synchronous active-high reset
//   data_in      in  N_BITS  operand value, or op code in [2:0]
//   enter        in  1       debounced button level, acts on rising edge
//   clear        in  1       abort sequence, back to operand A entry
//   chain        in  1       with enter in SHOW: reuse result as next A
//   op_a, op_b   out N_BITS  latched operands
//   op_sel       out 3       latched op code
//   result       out N_BITS  registered ALU result
//   overflow     out 1       registered ALU overflow
//   result_valid out 1       result/overflow held for display
//   op_err       out 1       last op code entered was unsupported
//   state_code   out 3       current state, drives the display prompt
//   op_count     out CNT_W   completed calculations, saturating
// -----------------------------------------------------------------------------
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int N_BITS = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BITS-1:0] data_in,
  input  logic              enter,
  input  logic              clear,
  input  logic              chain,
  output logic [N_BITS-1:0] op_a,
  output logic [N_BITS-1:0] op_b,
  output logic [2:0]        op_sel,
  output logic [N_BITS-1:0] result,
  output logic              overflow,
  output logic              result_valid,
  output logic              op_err,
  output logic [2:0]        state_code,
  output logic [CNT_W-1:0]  op_count
);

  state_e            state_q, state_d;
  logic              enter_q;
  logic              enter_edge_s;
  logic              op_legal_s;

  logic [N_BITS-1:0] op_a_q, op_a_d;
  logic [N_BITS-1:0] op_b_q, op_b_d;
  logic [2:0]        op_sel_q, op_sel_d;
  logic [N_BITS-1:0] result_q, result_d;
  logic              overflow_q, overflow_d;
  logic              valid_q, valid_d;
  logic              op_err_q, op_err_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic [N_BITS-1:0] alu_result_s;
  logic              alu_overflow_s;

  assign enter_edge_s = enter & ~enter_q;
  assign op_legal_s   = is_legal_op(data_in[2:0]);

  ALU_generalizado #(
    .n_bits (N_BITS)
  ) u_alu (
    .a        (op_a_q),
    .b        (op_b_q),
    .sel      (op_sel_q),
    .result   (alu_result_s),
    .overflow (alu_overflow_s)
  );

  // Button edge detector; keeps tracking the button even while clear is high
  // so a button held through clear cannot fire when clear drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      enter_q <= 1'b0;
    end else begin
      enter_q <= enter;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides any button action.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = WAIT_A;
    end else begin
      case (state_q)
        WAIT_A: begin
          if (enter_edge_s) state_d = WAIT_B;
          else              state_d = WAIT_A;
        end
        WAIT_B: begin
          if (enter_edge_s) state_d = WAIT_OP;
          else              state_d = WAIT_B;
        end
        WAIT_OP: begin
          if (enter_edge_s && op_legal_s) state_d = CALC;
          else                            state_d = WAIT_OP;
        end
        CALC: begin
          state_d = SHOW;
        end
        SHOW: begin
          if (enter_edge_s) begin
            if (chain) state_d = WAIT_B;
            else       state_d = WAIT_A;
          end else begin
            state_d = SHOW;
          end
        end
        default: begin
          state_d = WAIT_A;
        end
      endcase
    end
  end

  // Datapath next values: operand capture, op check, result capture.
  always_comb begin
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sel_d   = op_sel_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    op_err_d   = op_err_q;
    op_count_d = op_count_q;
    if (clear) begin
      // Everything but the completed-operation count is wiped.
      op_a_d     = {N_BITS{1'b0}};
      op_b_d     = {N_BITS{1'b0}};
      op_sel_d   = 3'b000;
      result_d   = {N_BITS{1'b0}};
      overflow_d = 1'b0;
      valid_d    = 1'b0;
      op_err_d   = 1'b0;
    end else begin
      case (state_q)
        WAIT_A: begin
          if (enter_edge_s) op_a_d = data_in;
          else              op_a_d = op_a_q;
        end
        WAIT_B: begin
          if (enter_edge_s) op_b_d = data_in;
          else              op_b_d = op_b_q;
        end
        WAIT_OP: begin
          if (enter_edge_s) begin
            if (op_legal_s) begin
              op_sel_d = data_in[2:0];
              op_err_d = 1'b0;
            end else begin
              // Rejected code leaves the previous op_sel in place.
              op_err_d = 1'b1;
            end
          end else begin
            op_err_d = op_err_q;
          end
        end
        CALC: begin
          result_d   = alu_result_s;
          overflow_d = alu_overflow_s;
          valid_d    = 1'b1;
          if (op_count_q != {CNT_W{1'b1}}) begin
            op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            op_count_d = op_count_q;
          end
        end
        SHOW: begin
          if (enter_edge_s) begin
            valid_d = 1'b0;
            if (chain) op_a_d = result_q;
            else       op_a_d = op_a_q;
          end else begin
            valid_d = valid_q;
          end
        end
        default: begin
          valid_d = valid_q;
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a_q     <= {N_BITS{1'b0}};
      op_b_q     <= {N_BITS{1'b0}};
      op_sel_q   <= 3'b000;
      result_q   <= {N_BITS{1'b0}};
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      op_err_q   <= 1'b0;
      op_count_q <= {CNT_W{1'b0}};
    end else begin
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sel_q   <= op_sel_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      op_err_q   <= op_err_d;
      op_count_q <= op_count_d;
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_sel       = op_sel_q;
  assign result       = result_q;
  assign overflow     = overflow_q;
  assign result_valid = valid_q;
  assign op_err       = op_err_q;
  assign state_code   = state_q;
  assign op_count     = op_count_q;

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencing controller for the generalized N-bit ALU. It walks the user through three entries: operand A, operand B, then the operation code, all taken from one shared data bus with an "enter" button. It then fires the ALU for one cycle and holds the registered result and overflow for the display path until the user acknowledges. Sits between the debounced switch/button front end and the VGA/7-seg display logic.

Parameters:
N_BITS, 8, operand/result width passed to the ALU
CNT_W, 8, width of the completed-operation counter (saturating)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
data_in  in  N_BITS  switch bus; operand value, or op code in bits [2:0]
enter  in  1  debounced button level; action taken on rising edge only
clear  in  1  level; abort the sequence and return to operand A entry
chain  in  1  level; sampled with enter in SHOW; reuse result as next A
op_a  out  N_BITS  latched operand A
op_b  out  N_BITS  latched operand B
op_sel  out  3  latched operation code
result  out  N_BITS  registered ALU result
overflow  out  1  registered ALU overflow
result_valid  out  1  high while result/overflow are held for display
op_err  out  1  high after an unsupported op code was entered, until next valid entry or clear
state_code  out  3  current state encoding, drives the display prompt
op_count  out  CNT_W  number of completed calculations, saturates at all-ones

Behaviour:
- Reset is synchronous and active-high; one clock. Reset dominates clear; clear dominates enter.
- Reset values: all outputs 0; state WAIT_A; edge-detect register 0.
- enter_edge = enter & ~enter_q, where enter_q is enter registered each cycle. Holding enter never repeats an action.
- States and encoding: WAIT_A=0, WAIT_B=1, WAIT_OP=2, CALC=3, SHOW=4.
- WAIT_A: on enter_edge, op_a <= data_in, then go to WAIT_B.
- WAIT_B: on enter_edge, op_b <= data_in, then go to WAIT_OP.
- WAIT_OP: on enter_edge, check data_in[2:0]:
  - Legal codes are 000 add, 001 mul, 100 sub, 010 and, 101 or.
  - Legal: op_sel <= code, op_err <= 0, go to CALC.
  - Illegal (011, 110, 111): op_err <= 1, op_sel unchanged, stay in WAIT_OP.
- CALC: lasts exactly one cycle. The ALU is combinational on op_a/op_b/op_sel.
  - result <= ALU result; overflow <= ALU overflow.
  - result_valid <= 1; op_count increments unless already saturated.
  - Go to SHOW.
- Latency: enter_edge accepted in WAIT_OP at cycle t, so state=CALC at t+1 and result_valid=1 with the final result at t+2.
- SHOW: result, overflow and result_valid hold until enter_edge.
  - chain=0: result_valid <= 0, go to WAIT_A; op_a/op_b keep their old values until overwritten.
  - chain=1: op_a <= result, result_valid <= 0, go to WAIT_B.
- clear in any state:
  - Next cycle: state WAIT_A; op_a, op_b, op_sel, result, overflow, result_valid and op_err all 0.
  - op_count is preserved; only reset zeroes it.
- clear and enter_edge in the same cycle: clear wins and the enter is discarded. enter_q still updates, so a held button does not fire after clear releases.
- Reset during CALC: the result is not written and op_count does not increment.
- Arithmetic width: every result is truncated to N_BITS, overflow rule as defined in the ALU. Sub is A + (~B + 1) modulo 2^N_BITS.
- No combinational path from inputs to outputs; every output is a register, and state_code is decoded from the state register.

Decomposition:
- Package alu_pkg holds:
  - the state enum (WAIT_A..SHOW, 3 bits);
  - op-code localparams OP_ADD=3'b000, OP_MUL=3'b001, OP_AND=3'b010, OP_SUB=3'b100, OP_OR=3'b101;
  - an is_legal_op function.
- One sub-module: the existing ALU_generalizado (n_bits=N_BITS), instantiated once. Its inputs are driven by op_a/op_b/op_sel.

Test Plan:
- Reset, then enter pulses with data 5, 3, 000 -> result=8, overflow=0, result_valid=1 exactly 2 cycles after the op enter, op_count=1.
- A=100, B=50, op=000 -> result=150 (0x96), overflow=1; A=3, B=4, op=001 -> result=12, overflow=0.
- A=5, B=7, op=100 -> result=0xFE, overflow=0. Holding enter high 10 cycles in WAIT_A -> only one operand latched, state WAIT_B.
- In WAIT_OP enter code 011 -> op_err=1, state stays 2. Then enter 010 with A=12, B=10 -> op_err=0, result=8.
- In SHOW with result=8, enter with chain=1, then B=2, op=010 -> op_a=8, result=0; op_count increments both times.
- clear asserted in WAIT_OP together with an enter edge -> next cycle state=0, all operands/flags 0, op_count unchanged. Reset asserted in CALC -> result=0, op_count=0.
